// File: rtl/wb_queue_if.sv
// Bus bundle for the writeback queue: ALU/load requests, the register-file
// write port, operand hazard lookups and occupancy.
interface wb_queue_if #(parameter int DEPTH = 4);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          alu_valid_i;
    logic [4:0]    alu_addr_i;
    logic [31:0]   alu_data_i;
    logic          alu_ready_o;
    logic          mem_valid_i;
    logic [4:0]    mem_addr_i;
    logic [31:0]   mem_data_i;
    logic          mem_ready_o;
    logic          write_enable_o;
    logic [4:0]    write_addr_o;
    logic [31:0]   write_data_o;
    logic [4:0]    lookup_addr_a_i;
    logic [4:0]    lookup_addr_b_i;
    logic          pending_a_o;
    logic          pending_b_o;
    logic [CW-1:0] count_o;

    modport slave (
        input  alu_valid_i, alu_addr_i, alu_data_i,
        input  mem_valid_i, mem_addr_i, mem_data_i,
        input  lookup_addr_a_i, lookup_addr_b_i,
        output alu_ready_o, mem_ready_o,
        output write_enable_o, write_addr_o, write_data_o,
        output pending_a_o, pending_b_o, count_o
    );

    modport master (
        output alu_valid_i, alu_addr_i, alu_data_i,
        output mem_valid_i, mem_addr_i, mem_data_i,
        output lookup_addr_a_i, lookup_addr_b_i,
        input  alu_ready_o, mem_ready_o,
        input  write_enable_o, write_addr_o, write_data_o,
        input  pending_a_o, pending_b_o, count_o
    );
endinterface

// File: rtl/wb_queue.sv
// Writeback queue: merges ALU and load results into one register-file write
// port in acceptance order, draining one entry per cycle; flags pending writes.
module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rsn_i,
    wb_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          we_q, we_d;
    logic [4:0]    waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;

    logic [4:0]    addr_mem_q [DEPTH];
    logic [31:0]   data_mem_q [DEPTH];

    logic          alu_ready_s, mem_ready_s, alu_push_s, mem_push_s, pop_s;
    logic [PW-1:0] mem_slot_s;
    logic [DEPTH-1:0] live_s;
    logic          pend_a_s, pend_b_s;

    // Acceptance, pointer/count next-state and drain of the head entry.
    always_comb begin
        alu_ready_s = (count_q < CW'(DEPTH));
        alu_push_s  = bus.alu_valid_i & alu_ready_s & (bus.alu_addr_i != 5'd0);
        // A same-cycle pop is deliberately not credited as free space.
        mem_ready_s = ((count_q + CW'(alu_push_s)) < CW'(DEPTH));
        mem_push_s  = bus.mem_valid_i & mem_ready_s & (bus.mem_addr_i != 5'd0);
        pop_s       = (count_q != {CW{1'b0}});
        mem_slot_s  = tail_q + PW'(alu_push_s);
        tail_d      = tail_q + PW'(alu_push_s) + PW'(mem_push_s);
        head_d      = head_q + PW'(pop_s);
        count_d     = count_q + CW'(alu_push_s) + CW'(mem_push_s) - CW'(pop_s);
        we_d        = pop_s;
        if (pop_s) begin
            waddr_d = addr_mem_q[head_q];
            wdata_d = data_mem_q[head_q];
        end else begin
            waddr_d = waddr_q;
            wdata_d = wdata_q;
        end
    end

    // Hazard lookup over live slots plus the write currently on the port.
    always_comb begin
        live_s   = {DEPTH{1'b0}};
        pend_a_s = 1'b0;
        pend_b_s = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            live_s[j] = ({1'b0, PW'(j) - head_q} < count_q);
        end
        for (int k = 0; k < DEPTH; k++) begin
            pend_a_s = pend_a_s | (live_s[k] & (addr_mem_q[k] == bus.lookup_addr_a_i));
            pend_b_s = pend_b_s | (live_s[k] & (addr_mem_q[k] == bus.lookup_addr_b_i));
        end
        pend_a_s = (bus.lookup_addr_a_i != 5'd0) &
                   (pend_a_s | (we_q & (waddr_q == bus.lookup_addr_a_i)));
        pend_b_s = (bus.lookup_addr_b_i != 5'd0) &
                   (pend_b_s | (we_q & (waddr_q == bus.lookup_addr_b_i)));
    end

    // Entry storage; contents are qualified by head/count so need no reset.
    always_ff @(posedge clk_i) begin
        if (alu_push_s) begin
            addr_mem_q[tail_q] <= bus.alu_addr_i;
            data_mem_q[tail_q] <= bus.alu_data_i;
        end
        if (mem_push_s) begin
            addr_mem_q[mem_slot_s] <= bus.mem_addr_i;
            data_mem_q[mem_slot_s] <= bus.mem_data_i;
        end
    end

    // Control state and registered write port.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            we_q    <= 1'b0;
            waddr_q <= 5'd0;
            wdata_q <= 32'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.alu_ready_o    = alu_ready_s;
    assign bus.mem_ready_o    = mem_ready_s;
    assign bus.write_enable_o = we_q;
    assign bus.write_addr_o   = waddr_q;
    assign bus.write_data_o   = wdata_q;
    assign bus.pending_a_o    = pend_a_s;
    assign bus.pending_b_o    = pend_b_s;
    assign bus.count_o        = count_q;
endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: accepted requests are queued in a model and
// compared against the register-file write port as entries drain.
module tb_wb_queue;
    localparam int DEPTH = 4;

    logic clk;
    logic rsn;

    wb_queue_if #(.DEPTH(DEPTH)) bus();

    wb_queue #(.DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rsn_i (rsn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [36:0] mq[$];
    logic        last_we;
    logic [4:0]  last_addr;
    logic [31:0] last_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: observed %h, expected %h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic exp_pend(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (last_we && last_addr == a) return 1'b1;
        foreach (mq[i]) begin
            if (mq[i][36:32] == a) return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock: drive requests, check handshake/lookups, then the write port.
    task automatic cycle(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         output logic m_acc);
        logic        exp_ar, exp_mr, a_push, exp_we;
        logic [36:0] head_e;
        bus.alu_valid_i     = av;
        bus.alu_addr_i      = aa;
        bus.alu_data_i      = ad;
        bus.mem_valid_i     = mv;
        bus.mem_addr_i      = ma;
        bus.mem_data_i      = md;
        bus.lookup_addr_a_i = 5'($urandom_range(0, 12));
        bus.lookup_addr_b_i = 5'($urandom_range(0, 12));
        #1;
        exp_ar = (mq.size() < DEPTH);
        a_push = av && exp_ar && (aa != 5'd0);
        exp_mr = ((mq.size() + int'(a_push)) < DEPTH);
        chk("alu_ready", 32'(bus.alu_ready_o), 32'(exp_ar));
        chk("mem_ready", 32'(bus.mem_ready_o), 32'(exp_mr));
        chk("count", 32'(bus.count_o), 32'(mq.size()));
        chk("pending_a", 32'(bus.pending_a_o), 32'(exp_pend(bus.lookup_addr_a_i)));
        chk("pending_b", 32'(bus.pending_b_o), 32'(exp_pend(bus.lookup_addr_b_i)));
        exp_we = (mq.size() > 0);
        head_e = 37'd0;
        if (exp_we) head_e = mq.pop_front();
        if (a_push) mq.push_back({aa, ad});
        m_acc = mv && exp_mr;
        if (m_acc && ma != 5'd0) mq.push_back({ma, md});
        @(posedge clk);
        #1;
        chk("write_enable", 32'(bus.write_enable_o), 32'(exp_we));
        if (exp_we) begin
            last_addr = head_e[36:32];
            last_data = head_e[31:0];
        end
        chk("write_addr", 32'(bus.write_addr_o), 32'(last_addr));
        chk("write_data", bus.write_data_o, last_data);
        last_we = exp_we;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
    endtask

    initial begin
        logic        acc;
        logic [4:0]  ma;
        logic [31:0] md;
        last_we   = 1'b0;
        last_addr = 5'd0;
        last_data = 32'd0;
        rsn = 1'b0;
        bus.alu_valid_i = 1'b1;  bus.alu_addr_i = 5'd7;  bus.alu_data_i = 32'hAAAA0007;
        bus.mem_valid_i = 1'b1;  bus.mem_addr_i = 5'd8;  bus.mem_data_i = 32'hBBBB0008;
        bus.lookup_addr_a_i = 5'd7;
        bus.lookup_addr_b_i = 5'd0;
        #3;
        chk("rst_alu_ready", 32'(bus.alu_ready_o), 32'd1);
        chk("rst_mem_ready", 32'(bus.mem_ready_o), 32'd1);
        chk("rst_count", 32'(bus.count_o), 32'd0);
        chk("rst_we", 32'(bus.write_enable_o), 32'd0);
        chk("rst_pending", 32'(bus.pending_a_o), 32'd0);
        #9;
        bus.alu_valid_i = 1'b0;
        bus.mem_valid_i = 1'b0;
        #5 rsn = 1'b1;

        // Single push and its pending window.
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, acc);
        idle(3);

        // Dual push: ALU ahead of MEM.
        cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, acc);
        idle(4);

        // Fill to 3, then MEM must stall behind ALU and go through next cycle.
        cycle(1'b1, 5'd9, 32'h900, 1'b1, 5'd10, 32'hA00, acc);
        cycle(1'b1, 5'd11, 32'hB00, 1'b1, 5'd12, 32'hC00, acc);
        ma = 5'd2; md = 32'h2222;
        cycle(1'b1, 5'd6, 32'h600, 1'b1, ma, md, acc);
        if (!acc) cycle(1'b0, 5'd0, 32'd0, 1'b1, ma, md, acc);
        idle(6);

        // Discarded x0 writes.
        cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0, acc);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h12345678, acc);
        idle(2);

        // Back-to-back ALU stream across pointer wrap.
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, 5'(i), 32'h1000 + 32'(i), 1'b0, 5'd0, 32'd0, acc);
        end
        idle(4);

        // Random mix with a held MEM request.
        ma = 5'd1; md = 32'd0;
        for (int i = 0; i < 300; i++) begin
            logic mv;
            mv = 1'($urandom_range(0, 1));
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 12)), $urandom,
                  mv, ma, md, acc);
            if (acc || !mv) begin
                ma = 5'($urandom_range(0, 12));
                md = $urandom;
            end
        end
        idle(6);

        // Reset with three entries queued.
        cycle(1'b1, 5'd13, 32'hD00, 1'b1, 5'd14, 32'hE00, acc);
        cycle(1'b1, 5'd15, 32'hF00, 1'b1, 5'd16, 32'hF01, acc);
        bus.alu_valid_i = 1'b0;
        bus.mem_valid_i = 1'b0;
        rsn = 1'b0;
        #1;
        chk("midrst_we", 32'(bus.write_enable_o), 32'd0);
        chk("midrst_count", 32'(bus.count_o), 32'd0);
        mq.delete();
        last_we   = 1'b0;
        last_addr = 5'd0;
        last_data = 32'd0;
        #2 rsn = 1'b1;
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two, >= 2.
REQ-002 clk_i  input  1  single clock; all state SHALL update on rising edge.
REQ-003 rsn_i  input  1  reset; asynchronous, active-low.
REQ-004 alu_valid_i  input  1  ALU writeback request.
REQ-005 alu_addr_i  input  5  ALU destination register.
REQ-006 alu_data_i  input  32  ALU result.
REQ-007 alu_ready_o  output  1  ALU request accepted this cycle when high with alu_valid_i.
REQ-008 mem_valid_i  input  1  load-unit writeback request.
REQ-009 mem_addr_i  input  5  load destination register.
REQ-010 mem_data_i  input  32  load data.
REQ-011 mem_ready_o  output  1  load request accepted this cycle when high with mem_valid_i.
REQ-012 write_enable_o  output  1  register-file write enable (registered).
REQ-013 write_addr_o  output  5  register-file write address (registered).
REQ-014 write_data_o  output  32  register-file write data (registered).
REQ-015 lookup_addr_a_i, lookup_addr_b_i  input  5 each  decode source operands.
REQ-016 pending_a_o, pending_b_o  output  1 each  write to that register not yet in the register file.
REQ-017 count_o  output  log2(DEPTH)+1  current occupancy.

Function
REQ-018 Queue SHALL be a circular FIFO: head/tail pointers of log2(DEPTH) bits wrapping modulo DEPTH, occupancy counter 0..DEPTH.
REQ-019 alu_ready_o SHALL be high iff count < DEPTH; free space from a same-cycle pop SHALL NOT be counted.
REQ-020 mem_ready_o SHALL be high iff count + (alu_valid_i & alu_ready_o & alu_addr_i!=0) < DEPTH.
REQ-021 Both accepted same cycle: ALU entry SHALL be enqueued ahead of MEM entry (ALU at tail, MEM at tail+1).
REQ-022 A handshaked request with address 0 SHALL be accepted (ready per REQ-019/020) but discarded: no entry, count unchanged.
REQ-023 Each cycle with count > 0, head entry SHALL be popped and loaded into write_*_o with write_enable_o=1 on that edge; with count = 0, write_enable_o SHALL be 0 next cycle, write_addr_o/write_data_o hold.
REQ-024 Latency: request accepted at edge N into empty queue SHALL appear on write_*_o after edge N+1; one drain per cycle, sustained throughput 1 write/cycle.
REQ-025 Count update: count_next = count + pushes(0..2) - pop(0/1); SHALL never exceed DEPTH or underflow.
REQ-026 pending_x_o SHALL be combinational: high iff lookup_addr_x_i != 0 and matches any valid queue entry or the current write_addr_o while write_enable_o=1.
REQ-027 Lookup of address 0 SHALL always return pending low.
REQ-028 Order of writes to the register file SHALL equal acceptance order; duplicate addresses are legal and retained.

Reset
REQ-029 rsn_i low SHALL asynchronously clear head, tail, count, write_enable_o, write_addr_o, write_data_o to 0; queue contents need not be cleared.
REQ-030 During reset alu_ready_o and mem_ready_o SHALL read as 1 (count=0); no request presented during reset is retained.
REQ-031 Reset asserted mid-operation SHALL drop all queued entries; first edge after release SHALL see write_enable_o=0.

Verification
REQ-032 Single push: ALU valid addr 5 data 0xDEADBEEF into empty queue at edge N -> edge N+1 write_enable_o=1, addr 5, data 0xDEADBEEF; pending_a_o (lookup 5) high from N to N+2.
REQ-033 Dual push: ALU (3,0x11) and MEM (4,0x22) same cycle -> writes (3,0x11) then (4,0x22) on consecutive cycles.
REQ-034 Full: DEPTH=4, count=3, both valid, nonzero addrs -> alu_ready_o=1, mem_ready_o=0; MEM held, accepted next cycle; count never exceeds 4.
REQ-035 x0 discard: ALU addr 0 data 0xFFFFFFFF -> alu_ready_o=1, count unchanged, no write_enable_o pulse, pending for lookup 0 low.
REQ-036 Wrap-around: 10 back-to-back ALU pushes addr 1..10 with concurrent drains -> register-file writes in order 1..10, no loss or duplication.
REQ-037 Reset mid-op: queue holding 3 entries, assert rsn_i low between edges -> write_enable_o and count_o 0 immediately; none of the 3 entries written after release.
